// File: rtl/alu_issue_scheduler_if.sv
// Dispatch, wakeup, flush and ALU-issue signals of the issue scheduler.
// slave is the scheduler side; master is the dispatch/ALU environment side.
interface alu_issue_scheduler_if #(
  parameter int NUM_REG  = 32,
  parameter int DEPTH    = 8,
  parameter int ALU_OP_W = 4,
  parameter int TAG_W    = 5
);
  localparam int PREG_W = $clog2(NUM_REG);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                flush;
  logic                disp_valid;
  logic                disp_ready;
  logic [ALU_OP_W-1:0] disp_alu_op;
  logic [TAG_W-1:0]    disp_tag;
  logic [PREG_W-1:0]   disp_p_dst;
  logic [PREG_W-1:0]   disp_p_src0;
  logic                disp_src0_rdy;
  logic [PREG_W-1:0]   disp_p_src1;
  logic                disp_src1_rdy;
  logic                wb_valid;
  logic [PREG_W-1:0]   wb_p_reg;
  logic                issue_valid;
  logic                issue_ready;
  logic [ALU_OP_W-1:0] issue_alu_op;
  logic [TAG_W-1:0]    issue_tag;
  logic [PREG_W-1:0]   issue_p_dst;
  logic [PREG_W-1:0]   issue_p_src0;
  logic [PREG_W-1:0]   issue_p_src1;
  logic [CNT_W-1:0]    occupancy;

  modport slave (
    input  flush, disp_valid, disp_alu_op, disp_tag, disp_p_dst,
           disp_p_src0, disp_src0_rdy, disp_p_src1, disp_src1_rdy,
           wb_valid, wb_p_reg, issue_ready,
    output disp_ready, issue_valid, issue_alu_op, issue_tag, issue_p_dst,
           issue_p_src0, issue_p_src1, occupancy
  );

  modport master (
    output flush, disp_valid, disp_alu_op, disp_tag, disp_p_dst,
           disp_p_src0, disp_src0_rdy, disp_p_src1, disp_src1_rdy,
           wb_valid, wb_p_reg, issue_ready,
    input  disp_ready, issue_valid, issue_alu_op, issue_tag, issue_p_dst,
           issue_p_src0, issue_p_src1, occupancy
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Compacting age-ordered issue queue: offers the oldest operand-ready entry to the ALU, 1-cycle dispatch/wakeup to issue.
// issue_ready low freezes the queue; disp_ready depends only on the registered count (no pass-through when full).
module alu_issue_scheduler #(
  parameter int NUM_REG  = 32,
  parameter int DEPTH    = 8,
  parameter int ALU_OP_W = 4,
  parameter int TAG_W    = 5
) (
  input logic                 clk,
  input logic                 n_rst,
  alu_issue_scheduler_if.slave bus
);
  localparam int PREG_W = $clog2(NUM_REG);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [TAG_W-1:0]    tag;
    logic [PREG_W-1:0]   dst;
    logic [PREG_W-1:0]   src0;
    logic [PREG_W-1:0]   src1;
    logic                rdy0;
    logic                rdy1;
  } entry_t;

  entry_t           slot_q   [DEPTH];
  entry_t           slot_d   [DEPTH];
  entry_t           slot_ext [DEPTH+1];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] slot_vld;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_fire;
  entry_t           disp_ent;
  entry_t           sel_ent;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = (CNT_W'(i) < count_q);
    end
  end

  // Scan from the youngest end so the last hit is the oldest ready slot.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_vld[i] && slot_q[i].rdy0 && slot_q[i].rdy1) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_ent    = slot_q[sel_idx];
  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign disp_fire  = bus.disp_valid & bus.disp_ready & ~bus.flush;

  assign bus.disp_ready   = (count_q < CNT_W'(DEPTH));
  assign bus.occupancy    = count_q;
  assign bus.issue_valid  = sel_found & ~bus.flush;
  assign bus.issue_alu_op = sel_ent.op;
  assign bus.issue_tag    = sel_ent.tag;
  assign bus.issue_p_dst  = sel_ent.dst;
  assign bus.issue_p_src0 = sel_ent.src0;
  assign bus.issue_p_src1 = sel_ent.src1;

  // A source being written back this very cycle is captured as already ready.
  always_comb begin
    disp_ent.op   = bus.disp_alu_op;
    disp_ent.tag  = bus.disp_tag;
    disp_ent.dst  = bus.disp_p_dst;
    disp_ent.src0 = bus.disp_p_src0;
    disp_ent.src1 = bus.disp_p_src1;
    disp_ent.rdy0 = bus.disp_src0_rdy | (bus.wb_valid & (bus.wb_p_reg == bus.disp_p_src0));
    disp_ent.rdy1 = bus.disp_src1_rdy | (bus.wb_valid & (bus.wb_p_reg == bus.disp_p_src1));
  end

  always_comb begin : next_slots
    entry_t e;
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_ext[i] = slot_q[i];
    end
    slot_ext[DEPTH] = '0;
    wr_idx = issue_fire ? (count_q - CNT_W'(1)) : count_q;
    for (int i = 0; i < DEPTH; i++) begin
      e = (issue_fire && (IDX_W'(i) >= sel_idx)) ? slot_ext[i+1] : slot_ext[i];
      // Wakeup is applied after the shift so moved entries still see the broadcast.
      if (bus.wb_valid && (e.src0 == bus.wb_p_reg)) e.rdy0 = 1'b1;
      if (bus.wb_valid && (e.src1 == bus.wb_p_reg)) e.rdy1 = 1'b1;
      if (disp_fire && (CNT_W'(i) == wr_idx)) e = disp_ent;
      slot_d[i] = e;
    end
  end

  assign count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

  always_ff @(posedge clk) begin
    if (!n_rst || bus.flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload needs no reset: only slots below count are ever looked at.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!n_rst)
    count_q <= CNT_W'(DEPTH));
  a_issue_slot_valid : assert property (@(posedge clk) disable iff (!n_rst)
    bus.issue_valid |-> slot_vld[sel_idx]);

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed table, multi-cycle corner sequences, then random traffic vs a queue model.
module tb_alu_issue_scheduler;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.NUM_REG(32), .DEPTH(DEPTH), .ALU_OP_W(4), .TAG_W(5)) bus ();

  alu_issue_scheduler #(.NUM_REG(32), .DEPTH(DEPTH), .ALU_OP_W(4), .TAG_W(5)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: a plain age-ordered list of entries.
  typedef struct {
    int op; int tag; int dst; int s0; int s1; bit r0; bit r1;
  } ment_t;
  ment_t mq[$];

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r0 && mq[i].r1) return i;
    end
    return -1;
  endfunction

  task automatic model_update();
    int s;
    bit dr;
    ment_t e;
    if (!n_rst || bus.flush) begin
      mq.delete();
    end else begin
      s  = m_sel();
      dr = (mq.size() < DEPTH);
      if (s >= 0 && bus.issue_ready) mq.delete(s);
      if (bus.wb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].s0 == int'(bus.wb_p_reg)) mq[i].r0 = 1'b1;
          if (mq[i].s1 == int'(bus.wb_p_reg)) mq[i].r1 = 1'b1;
        end
      end
      if (bus.disp_valid && dr) begin
        e.op  = int'(bus.disp_alu_op);
        e.tag = int'(bus.disp_tag);
        e.dst = int'(bus.disp_p_dst);
        e.s0  = int'(bus.disp_p_src0);
        e.s1  = int'(bus.disp_p_src1);
        e.r0  = bus.disp_src0_rdy || (bus.wb_valid && bus.wb_p_reg == bus.disp_p_src0);
        e.r1  = bus.disp_src1_rdy || (bus.wb_valid && bus.wb_p_reg == bus.disp_p_src1);
        mq.push_back(e);
      end
    end
  endtask

  task automatic model_check(input string nm);
    int s;
    bit e_iv;
    s    = m_sel();
    e_iv = (s >= 0) && !bus.flush;
    chk({nm, "/issue_valid"}, 32'(bus.issue_valid), 32'(e_iv));
    if (e_iv) begin
      chk({nm, "/issue_tag"},  32'(bus.issue_tag),    mq[s].tag);
      chk({nm, "/issue_dst"},  32'(bus.issue_p_dst),  mq[s].dst);
      chk({nm, "/issue_op"},   32'(bus.issue_alu_op), mq[s].op);
      chk({nm, "/issue_src0"}, 32'(bus.issue_p_src0), mq[s].s0);
      chk({nm, "/issue_src1"}, 32'(bus.issue_p_src1), mq[s].s1);
    end
    chk({nm, "/disp_ready"}, 32'(bus.disp_ready), 32'(mq.size() < DEPTH));
    chk({nm, "/occupancy"},  32'(bus.occupancy),  mq.size());
  endtask

  task automatic drv(input bit fl, input bit dv, input int op, input int tag, input int dst,
                     input int s0, input bit r0, input int s1, input bit r1,
                     input bit wv, input int wr, input bit ir);
    bus.flush         = fl;
    bus.disp_valid    = dv;
    bus.disp_alu_op   = 4'(op);
    bus.disp_tag      = 5'(tag);
    bus.disp_p_dst    = 5'(dst);
    bus.disp_p_src0   = 5'(s0);
    bus.disp_src0_rdy = r0;
    bus.disp_p_src1   = 5'(s1);
    bus.disp_src1_rdy = r1;
    bus.wb_valid      = wv;
    bus.wb_p_reg      = 5'(wr);
    bus.issue_ready   = ir;
  endtask

  task automatic idle(input bit ir);
    drv(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, ir);
  endtask

  task automatic settle_check(input string nm);
    #1;
    model_check(nm);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    bit dv; int op; int tag; int dst; int s0; bit r0; int s1; bit r1;
    bit wv; int wr; bit ir;
    bit e_iv; int e_tag; int e_dst; int e_occ;
  } row_t;
  localparam int NROWS = 17;
  row_t tbl[NROWS];

  function automatic row_t mk(bit dv, int op, int tag, int dst, int s0, bit r0, int s1, bit r1,
                              bit wv, int wr, bit ir, bit e_iv, int e_tag, int e_dst, int e_occ);
    row_t r;
    r.dv = dv; r.op = op; r.tag = tag; r.dst = dst; r.s0 = s0; r.r0 = r0; r.s1 = s1; r.r1 = r1;
    r.wv = wv; r.wr = wr; r.ir = ir;
    r.e_iv = e_iv; r.e_tag = e_tag; r.e_dst = e_dst; r.e_occ = e_occ;
    return r;
  endfunction

  initial begin
    int ir_pct;
    idle(1'b0);

    // Expectations are sampled with the row's inputs applied, before the edge.
    tbl[0]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  0, 0, 0,  0);
    tbl[1]  = mk(1, 3, 1, 10,  4, 1,  5, 1,  0, 0,  1,  0, 0, 0,  0);
    tbl[2]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  1, 1, 10, 1);
    tbl[3]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  0, 0, 0,  0);
    tbl[4]  = mk(1, 1, 1, 11,  7, 0,  6, 1,  0, 0,  1,  0, 0, 0,  0);
    tbl[5]  = mk(1, 2, 2, 12,  1, 1,  2, 1,  0, 0,  1,  0, 0, 0,  1);
    tbl[6]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  1, 2, 12, 2);
    tbl[7]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  1, 7,  1,  0, 0, 0,  1);
    tbl[8]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  1, 1, 11, 1);
    tbl[9]  = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  0, 0, 0,  0);
    tbl[10] = mk(1, 5, 3, 20,  9, 0,  8, 1,  1, 9,  1,  0, 0, 0,  0);
    tbl[11] = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  1, 3, 20, 1);
    tbl[12] = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  0, 0, 0,  0);
    tbl[13] = mk(1, 6, 4, 21, 13, 0, 13, 0,  0, 0,  1,  0, 0, 0,  0);
    tbl[14] = mk(0, 0, 0, 0,   0, 0,  0, 0,  1, 13, 1,  0, 0, 0,  1);
    tbl[15] = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  1, 4, 21, 1);
    tbl[16] = mk(0, 0, 0, 0,   0, 0,  0, 0,  0, 0,  1,  0, 0, 0,  0);

    repeat (2) @(posedge clk);
    mq.delete();
    #1;
    n_rst = 1'b1;

    for (int r = 0; r < NROWS; r++) begin
      drv(1'b0, tbl[r].dv, tbl[r].op, tbl[r].tag, tbl[r].dst, tbl[r].s0, tbl[r].r0,
          tbl[r].s1, tbl[r].r1, tbl[r].wv, tbl[r].wr, tbl[r].ir);
      #1;
      chk($sformatf("row%0d/issue_valid", r), 32'(bus.issue_valid), 32'(tbl[r].e_iv));
      if (tbl[r].e_iv) begin
        chk($sformatf("row%0d/issue_tag", r), 32'(bus.issue_tag),   tbl[r].e_tag);
        chk($sformatf("row%0d/issue_dst", r), 32'(bus.issue_p_dst), tbl[r].e_dst);
      end
      chk($sformatf("row%0d/occupancy", r),  32'(bus.occupancy),  tbl[r].e_occ);
      chk($sformatf("row%0d/disp_ready", r), 32'(bus.disp_ready), 32'd1);
      edge_step();
    end

    // Fill to capacity with the ALU stalled, reject a 9th, then drain in order.
    for (int k = 0; k < DEPTH; k++) begin
      drv(1'b0, 1'b1, k, 20 + k, k + 1, 2, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
      settle_check("fill");
      chk("fill/disp_ready", 32'(bus.disp_ready), 32'd1);
      edge_step();
    end
    drv(1'b0, 1'b1, 1, 28, 9, 2, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
    settle_check("full");
    chk("full/disp_ready", 32'(bus.disp_ready), 32'd0);
    chk("full/occupancy",  32'(bus.occupancy),  32'd8);
    edge_step();
    chk("full/no_accept_occ", 32'(bus.occupancy), 32'd8);
    for (int k = 0; k < DEPTH; k++) begin
      idle(1'b1);
      settle_check("drain");
      chk($sformatf("drain%0d/issue_tag", k), 32'(bus.issue_tag), 32'(20 + k));
      edge_step();
    end
    chk("drain/occupancy", 32'(bus.occupancy), 32'd0);

    // Flush beats dispatch, issue and wakeup.
    for (int k = 0; k < 5; k++) begin
      drv(1'b0, 1'b1, k, k, k, 30, 1'b1, 31, 1'b1, 1'b0, 0, 1'b0);
      settle_check("pre_flush");
      edge_step();
    end
    drv(1'b1, 1'b1, 7, 17, 17, 30, 1'b1, 31, 1'b1, 1'b1, 30, 1'b1);
    settle_check("flush");
    chk("flush/issue_valid", 32'(bus.issue_valid), 32'd0);
    edge_step();
    idle(1'b1);
    settle_check("post_flush");
    chk("post_flush/occupancy",   32'(bus.occupancy),   32'd0);
    chk("post_flush/issue_valid", 32'(bus.issue_valid), 32'd0);
    edge_step();

    // Full queue, issue from slot 2 while a wakeup hits an entry that shifts down.
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 2) drv(1'b0, 1'b1, k, k, k, 1, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
      else        drv(1'b0, 1'b1, k, k, k, 16 + k, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0);
      settle_check("fill2");
      edge_step();
    end
    drv(1'b0, 1'b1, 9, 9, 9, 1, 1'b1, 1, 1'b1, 1'b1, 21, 1'b1);
    settle_check("mid_issue");
    chk("mid_issue/issue_tag",  32'(bus.issue_tag),  32'd2);
    chk("mid_issue/disp_ready", 32'(bus.disp_ready), 32'd0);
    edge_step();
    chk("mid_issue/occupancy",  32'(bus.occupancy),  32'd7);
    chk("mid_issue/disp_ready_next", 32'(bus.disp_ready), 32'd1);
    drv(1'b0, 1'b1, 9, 9, 9, 1, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
    settle_check("shifted_wake");
    chk("shifted_wake/issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("shifted_wake/issue_tag",   32'(bus.issue_tag),   32'd5);
    edge_step();
    chk("refill/occupancy", 32'(bus.occupancy), 32'd8);
    drv(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    edge_step();

    // Random traffic in phases of different ALU acceptance rates.
    for (int c = 0; c < 2400; c++) begin
      ir_pct = (c < 800) ? 30 : ((c < 1600) ? 85 : 60);
      drv($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 60,
          $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 7), $urandom_range(0, 3) == 0,
          $urandom_range(0, 7), $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 99) < ir_pct);
      settle_check("rand");
      edge_step();
    end

    // Reset in the middle of traffic discards everything.
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b1, k, k, k, 6, 1'b0, 6, 1'b0, 1'b0, 0, 1'b0);
      settle_check("pre_rst");
      edge_step();
    end
    drv(1'b0, 1'b1, 1, 1, 1, 2, 1'b1, 2, 1'b1, 1'b1, 6, 1'b1);
    n_rst = 1'b0;
    settle_check("in_rst");
    edge_step();
    n_rst = 1'b1;
    idle(1'b1);
    settle_check("post_rst");
    chk("post_rst/occupancy",   32'(bus.occupancy),   32'd0);
    chk("post_rst/issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("post_rst/disp_ready",  32'(bus.disp_ready),  32'd1);
    edge_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
